// File: rtl/mem_port.sv
// -----------------------------------------------------------------------------
// mem_port -- single-outstanding memory access port between the CPU datapath
// and an external request/acknowledge memory.
//
// A CPU request seen while idle is latched into registered mem_* outputs and
// held until the memory acknowledges it. The cycle after the ack is a one-cycle
// completion window (DONE). During DONE, cpu_stall is low so the datapath can
// advance. A cpu_req still asserted in DONE belongs to the finishing access and
// does not start a new access.
//
// Optional feature (compile-time macro MEM_TIMEOUT_EN):
//   A BUSY-cycle counter aborts an access that has been outstanding for
//   TIMEOUT cycles without an ack. When that happens, err is set (sticky until
//   rst), and a read returns 16'hFFFF. Without the macro, BUSY waits
//   indefinitely and err is tied to 0.
//
// Parameters:
//   TIMEOUT    max BUSY cycles before abort (used only with MEM_TIMEOUT_EN)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   cpu_req    datapath requests an access this cycle
//   cpu_we     1 = write, 0 = read
//   cpu_addr   access address
//   cpu_wdata  write data
//   cpu_rdata  registered read data back to the datapath
//   cpu_stall  combinational freeze for controller and datapath enables
//   mem_req    registered request to external memory
//   mem_we     registered write strobe, meaningful while mem_req = 1
//   mem_addr   registered latched address
//   mem_wdata  registered latched write data
//   mem_ack    memory completion, meaningful only while mem_req = 1
//   mem_rdata  memory read data, valid in the ack cycle
//   err        sticky timeout flag
// -----------------------------------------------------------------------------
module mem_port #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]  stateQ, stateD;
  logic        memReqQ, memReqD;
  logic        memWeQ, memWeD;
  logic [15:0] memAddrQ, memAddrD;
  logic [15:0] memWdataQ, memWdataD;
  logic [15:0] cpuRdataQ, cpuRdataD;

`ifdef MEM_TIMEOUT_EN
  // The counter holds the index of the current BUSY cycle, so it only
  // needs to reach TIMEOUT-1.
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cntQ, cntD;
  logic            errQ, errD;
`else
  logic unusedTimeout;
  assign unusedTimeout = (TIMEOUT != 0);
`endif

  // Next-state and datapath-latch logic
  always_comb begin
    stateD    = stateQ;
    memReqD   = memReqQ;
    memWeD    = memWeQ;
    memAddrD  = memAddrQ;
    memWdataD = memWdataQ;
    cpuRdataD = cpuRdataQ;
`ifdef MEM_TIMEOUT_EN
    cntD      = cntQ;
    errD      = errQ;
`endif

    case (stateQ)
      StIdle: begin
        // An ack arriving here is stale and is ignored.
        if (cpu_req) begin
          stateD    = StBusy;
          memReqD   = 1'b1;
          memWeD    = cpu_we;
          memAddrD  = cpu_addr;
          memWdataD = cpu_wdata;
`ifdef MEM_TIMEOUT_EN
          cntD      = '0;
`endif
        end
      end

      StBusy: begin
        // An ack always wins over a timeout in the same cycle.
        if (mem_ack) begin
          stateD  = StDone;
          memReqD = 1'b0;
          if (!memWeQ) begin
            cpuRdataD = mem_rdata;
          end
`ifdef MEM_TIMEOUT_EN
        end else if (cntQ == CntLast) begin
          stateD  = StDone;
          memReqD = 1'b0;
          errD    = 1'b1;
          if (!memWeQ) begin
            cpuRdataD = 16'hFFFF;
          end
        end else begin
          cntD = cntQ + 1'b1;
`endif
        end
      end

      StDone: begin
        // One-cycle completion window. A cpu_req seen here is the finishing
        // access, not a new one.
        stateD = StIdle;
      end

      default: begin
        stateD  = StIdle;
        memReqD = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= StIdle;
      memReqQ   <= 1'b0;
      memWeQ    <= 1'b0;
      memAddrQ  <= 16'h0000;
      memWdataQ <= 16'h0000;
      cpuRdataQ <= 16'h0000;
`ifdef MEM_TIMEOUT_EN
      cntQ      <= '0;
      errQ      <= 1'b0;
`endif
    end else begin
      stateQ    <= stateD;
      memReqQ   <= memReqD;
      memWeQ    <= memWeD;
      memAddrQ  <= memAddrD;
      memWdataQ <= memWdataD;
      cpuRdataQ <= cpuRdataD;
`ifdef MEM_TIMEOUT_EN
      cntQ      <= cntD;
      errQ      <= errD;
`endif
    end
  end

  assign mem_req   = memReqQ;
  assign mem_we    = memWeQ;
  assign mem_addr  = memAddrQ;
  assign mem_wdata = memWdataQ;
  assign cpu_rdata = cpuRdataQ;

  // Release the stall in DONE so the datapath advances exactly once per access.
  assign cpu_stall = cpu_req & (stateQ != StDone);

`ifdef MEM_TIMEOUT_EN
  assign err = errQ;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/mem_port.md
MEM_PORT -- requirements
Module: mem_port

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 16, max BUSY cycles before abort (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have port: clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: cpu_req  input  1  datapath requests a memory access this cycle.
REQ-005 SHALL have port: cpu_we  input  1  1 = write, 0 = read.
REQ-006 SHALL have port: cpu_addr  input  16  access address from the datapath address mux.
REQ-007 SHALL have port: cpu_wdata  input  16  write data from the datapath write-data mux.
REQ-008 SHALL have port: cpu_rdata  output  16  registered read data to the datapath.
REQ-009 SHALL have port: cpu_stall  output  1  freeze controller state and all datapath enables.
REQ-010 SHALL have port: mem_req  output  1  request to external memory, registered.
REQ-011 SHALL have port: mem_we  output  1  write strobe, qualified by mem_req, registered.
REQ-012 SHALL have port: mem_addr  output  16  latched address, registered.
REQ-013 SHALL have port: mem_wdata  output  16  latched write data, registered.
REQ-014 SHALL have port: mem_ack  input  1  memory completion, valid only while mem_req=1.
REQ-015 SHALL have port: mem_rdata  input  16  read data, valid in the mem_ack cycle.
REQ-016 SHALL have port: err  output  1  sticky timeout flag.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-018 In IDLE with cpu_req=1, SHALL latch cpu_addr/cpu_wdata/cpu_we into mem_addr/mem_wdata/mem_we and go to BUSY; mem_req=1 from the next cycle.
REQ-019 In IDLE with cpu_req=0, SHALL stay in IDLE with mem_req=0.
REQ-020 In BUSY, SHALL hold mem_req=1 and latched mem_* values constant; cpu_* changes SHALL be ignored.
REQ-021 In BUSY with mem_ack=1, SHALL go to DONE and deassert mem_req in the next cycle. On a read, mem_rdata SHALL be captured into cpu_rdata at that edge.
REQ-022 cpu_rdata SHALL change only on a read ack (or on timeout, REQ-031); writes leave it unchanged.
REQ-023 DONE SHALL last exactly one cycle, then go to IDLE; cpu_req seen in DONE belongs to the completing access and SHALL NOT start a new one.
REQ-024 cpu_stall SHALL be combinational: cpu_req & (state != DONE).
REQ-025 Minimum access latency SHALL be 3 cycles, with cpu_req at c0, mem_ack at c1 and cpu_stall=0 at c2; each extra wait cycle adds one.
REQ-026 Back-to-back accesses: the second cpu_req, seen in IDLE the cycle after DONE, SHALL start normally; there is no dead cycle beyond IDLE.
REQ-027 mem_ack in IDLE or DONE SHALL be ignored.

Reset
REQ-028 On rst=1 at a clock edge, SHALL force state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, err=0 and the timeout counter=0.
REQ-029 Reset mid-BUSY SHALL drop mem_req the next cycle; an ack arriving after reset SHALL be ignored (REQ-027).

Configuration
REQ-030 Macro MEM_TIMEOUT_EN defined: SHALL include a BUSY-cycle counter that clears on entry to BUSY and increments each BUSY cycle without ack.
REQ-031 With MEM_TIMEOUT_EN, the counter reaching TIMEOUT-1 without ack SHALL cause: go to DONE, drop mem_req, set err=1 (sticky until rst), and load cpu_rdata=16'hFFFF on reads. mem_req therefore lasts exactly TIMEOUT cycles.
REQ-032 With MEM_TIMEOUT_EN, an ack in the timeout cycle SHALL win: normal completion, err unchanged.
REQ-033 Macro undefined: counter SHALL be absent, BUSY SHALL wait indefinitely, and err SHALL be constant 0.

Verification
REQ-034 Read: cpu_req at c0 with addr 0x0010, mem_ack at c1 with rdata 0xBEEF -> mem_req=1 only at c1; cpu_stall=1 at c0-c1, 0 at c2; cpu_rdata=0xBEEF at c2.
REQ-035 Write: addr 0x1234, wdata 0x5A5A, ack at c4 -> mem_req/mem_we=1 at c1-c4; cpu_stall low at c5; cpu_rdata unchanged.
REQ-036 Two consecutive reads, each acked next cycle -> second mem_req at c4; total 6 cycles; both data values returned in order.
REQ-037 cpu_addr changed to 0xFFFF during BUSY -> mem_addr keeps the latched 0x0010.
REQ-038 rst at c2 of a pending read -> mem_req=0 at c3; ack at c3 ignored; state IDLE; cpu_rdata=0.
REQ-039 With MEM_TIMEOUT_EN and TIMEOUT=4, read never acked -> mem_req high 4 cycles, err=1, cpu_rdata=0xFFFF, stall released. Without the macro -> stall stays high for 100+ cycles and err=0.
